stream_xor_engine: RTL and testbench
====================================

# stream_xor_engine

Keystream consumer for the stream-cipher cores. Sits downstream of a block-oriented keystream generator (e.g. the Trivium wrapper) and takes its `DATA_WIDTH`-bit keystream blocks over the `end_block`/`next_data` handshake. It slices each block into `WORD_WIDTH`-bit words and XORs them, one per accepted word, with a valid/ready data stream. The same block serves as encryptor or decryptor.

## Interface
- `DATA_WIDTH`, 80: keystream block width. Must equal the generator's block width.
- `WORD_WIDTH`, 8: data word width. `DATA_WIDTH % WORD_WIDTH == 0` is required; elaboration fails otherwise.
- `clk` input 1: single clock, all logic on its rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `ks_block_i` input `DATA_WIDTH`: keystream block from the generator. Bit 0 is the first keystream bit generated.
- `ks_end_block_i` input 1: generator's `end_block`. When high, the block is complete and is held until `ks_next_data_o`.
- `ks_next_data_o` output 1: one-cycle request to the generator's `next_data`.
- `data_valid_i` input 1: input word valid.
- `data_ready_o` output 1: input word accepted when both valid and ready are high.
- `data_i` input `WORD_WIDTH`: plaintext or ciphertext word.
- `out_valid_o` output 1: output word valid.
- `out_ready_i` input 1: downstream accepts the output word.
- `data_o` output `WORD_WIDTH`: XOR result.
- `ks_block_cnt_o` output 16: number of keystream blocks captured. Wraps mod 2^16.

## Operation
- `NWORDS = DATA_WIDTH/WORD_WIDTH`. Word index `idx` has width `max(1,$clog2(NWORDS))`.
- Word k of a block uses `ks_buf[k*WORD_WIDTH +: WORD_WIDTH]`, with k running 0..NWORDS-1 in order.
- FSM, 2 states, reset state WAIT_KS.
  - **WAIT_KS**
    - `data_ready_o` is 0.
    - If `ks_end_block_i` = 1: set `ks_buf <= ks_block_i`, `idx <= 0`, `ks_block_cnt_o++`, assert `ks_next_data_o` combinationally this cycle, and go to RUN.
  - **RUN**
    - `data_ready_o = !out_valid_o | out_ready_i` (single-stage output register).
    - On an input handshake: `data_o <= data_i ^ ks_buf[idx]`, `out_valid_o <= 1`, `idx++`.
    - On a handshake with `idx == NWORDS-1`:
      - If `ks_end_block_i` = 1 (fast path): reload `ks_buf`, set `idx <= 0`, increment the count, pulse `ks_next_data_o`, and stay in RUN.
      - Otherwise go to WAIT_KS.
- Output register:
  - `out_valid_o` clears when `out_ready_i` = 1 and no new handshake occurs in the same cycle.
  - `data_o` holds its value while `out_valid_o && !out_ready_i`.
- `ks_next_data_o` is asserted only in a cycle where `ks_end_block_i` = 1 and the buffer is captured at that edge. It is never asserted otherwise and never for two consecutive cycles.
- `ks_end_block_i` falling while in RUN is legal; it is the generator refilling in the background and has no effect.
- Keystream words are never skipped or reused. Words consumed equal words output, in order.

## Timing
- Reset (`rst` = 0, asynchronous) values:
  - State WAIT_KS.
  - `out_valid_o` = 0, `data_o` = 0, `ks_next_data_o` = 0, `data_ready_o` = 0.
  - `ks_block_cnt_o` = 0, `idx` = 0, `ks_buf` = 0.
- Reset mid-block discards the buffer and any pending output word. The generator is reset by the same system reset.
- Latency: input accepted at edge t produces `data_o`/`out_valid_o` valid right after edge t (1 cycle).
- Throughput:
  - 1 word/cycle within a block.
  - 0 bubble cycles at a block boundary if `ks_end_block_i` is already high.
  - Otherwise ready stays low until the cycle after `ks_end_block_i` rises (capture edge, then RUN).
- First block after reset: capture occurs on the first edge with `ks_end_block_i` = 1, after the generator's warm-up.
- Backpressure: with `out_ready_i` = 0 and `out_valid_o` = 1, `data_ready_o` = 0 and `idx` freezes.

## Test plan
- **Basic block:** `ks_block_i`=80'h0123456789ABCDEF0011 with `ks_end_block_i` high, then ten words `data_i`=8'h00, `out_ready_i`=1.
  - Required: `data_o` = 11,00,EF,CD,AB,89,67,45,23,01 on consecutive cycles.
  - Required: one `ks_next_data_o` pulse; `ks_block_cnt_o`=1.
- **Round trip:** run the output of one instance through a second instance with an identical keystream. The 40 recovered words must equal the inputs (random data).
- **Fast path:** `ks_end_block_i` already high when word 9 is accepted.
  - Required: 20 words stream with no ready-low cycle.
  - Required: exactly 2 `ks_next_data_o` pulses; count = 2.
- **Starved block:** `ks_end_block_i` low for 30 cycles after word 9.
  - Required: `data_ready_o`=0 and `ks_next_data_o`=0 throughout.
  - Required: resume on the cycle after `ks_end_block_i` rises, with word 0 of the new block.
- **Backpressure:** `out_ready_i`=0 for 5 cycles mid-block.
  - Required: `data_o` stable, `data_ready_o`=0, no word lost or duplicated.
  - Required: output sequence identical to the unstalled run.
- **Async reset at word 4:** drive `rst` low.
  - Required: all outputs reach reset values before the next edge.
  - Required: after release, the next word uses word 0 of a newly captured block.

Source files
------------

// File: rtl/stream_xor_engine.sv
// Keystream consumer: captures DATA_WIDTH-bit keystream blocks from a generator
// and XORs them, one WORD_WIDTH slice at a time, into a valid/ready word stream.
`timescale 1ns/1ps

module stream_xor_engine #(
    parameter int DATA_WIDTH = 80,
    parameter int WORD_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ks_block_i,
    input  logic                  ks_end_block_i,
    output logic                  ks_next_data_o,
    input  logic                  data_valid_i,
    output logic                  data_ready_o,
    input  logic [WORD_WIDTH-1:0] data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [WORD_WIDTH-1:0] data_o,
    output logic [15:0]           ks_block_cnt_o,
    output logic                  dbg_state_o
);

    localparam int NWORDS = DATA_WIDTH / WORD_WIDTH;
    localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    if (DATA_WIDTH % WORD_WIDTH != 0) begin : g_bad_width
        $error("stream_xor_engine: DATA_WIDTH must be a multiple of WORD_WIDTH");
    end

    typedef enum logic {
        WAIT_KS = 1'b0,
        RUN     = 1'b1
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_ks_buf;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_out_valid;
    logic [WORD_WIDTH-1:0] r_data;
    logic [15:0]           r_blk_cnt;

    logic [WORD_WIDTH-1:0] w_ks_words [NWORDS];
    logic                  w_ready;
    logic                  w_hs;
    logic                  w_last;
    logic                  w_capture;

    // Word k of the buffer is the k-th keystream word, lowest bits first.
    for (genvar k = 0; k < NWORDS; k++) begin : g_words
        assign w_ks_words[k] = r_ks_buf[k*WORD_WIDTH +: WORD_WIDTH];
    end

    // Handshake: a word moves on a rising edge where data_valid_i && data_ready_o.
    // Ready only in RUN and only while the single output register can take a word.
    assign w_ready = (r_state == RUN) && (!r_out_valid || out_ready_i);
    assign w_hs    = data_valid_i && w_ready;
    assign w_last  = (r_idx == LAST_IDX);

    // The next_data request is exactly the capture condition; gating with rst
    // keeps it low while reset is asserted.
    assign w_capture = rst && ks_end_block_i &&
                       ((r_state == WAIT_KS) || (w_hs && w_last));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= WAIT_KS;
            r_ks_buf    <= '0;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_data      <= '0;
            r_blk_cnt   <= '0;
        end else begin
            if (w_hs) begin
                r_data      <= data_i ^ w_ks_words[r_idx];
                r_out_valid <= 1'b1;
            end else if (out_ready_i) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                WAIT_KS: begin
                    if (ks_end_block_i) begin
                        r_ks_buf  <= ks_block_i;
                        r_idx     <= '0;
                        r_blk_cnt <= r_blk_cnt + 16'd1;
                        r_state   <= RUN;
                    end
                end
                RUN: begin
                    if (w_hs) begin
                        if (w_last) begin
                            r_idx <= '0;
                            if (ks_end_block_i) begin
                                r_ks_buf  <= ks_block_i;
                                r_blk_cnt <= r_blk_cnt + 16'd1;
                            end else begin
                                r_state <= WAIT_KS;
                            end
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                default: r_state <= WAIT_KS;
            endcase
        end
    end

    assign ks_next_data_o = w_capture;
    assign data_ready_o   = w_ready;
    assign out_valid_o    = r_out_valid;
    assign data_o         = r_data;
    assign ks_block_cnt_o = r_blk_cnt;
    assign dbg_state_o    = r_state;

endmodule

// File: tb/tb_stream_xor_engine.sv
// Directed bench for stream_xor_engine: a keystream generator model, an
// encrypt instance checked against a scoreboard, and a decrypt instance.
`timescale 1ns/1ps

module tb_stream_xor_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [79:0] ks_block;
    logic        ks_end;

    logic        a_next, a_valid, a_ready, a_out_valid, a_out_ready, a_dbg;
    logic [7:0]  a_data, a_data_o;
    logic [15:0] a_cnt;
    logic        b_next, b_valid, b_ready, b_out_valid, b_out_ready, b_dbg;
    logic [7:0]  b_data, b_data_o;
    logic [15:0] b_cnt;

    stream_xor_engine #(.DATA_WIDTH(80), .WORD_WIDTH(8)) u_enc (
        .clk(clk), .rst(rst), .ks_block_i(ks_block), .ks_end_block_i(ks_end),
        .ks_next_data_o(a_next), .data_valid_i(a_valid), .data_ready_o(a_ready),
        .data_i(a_data), .out_valid_o(a_out_valid), .out_ready_i(a_out_ready),
        .data_o(a_data_o), .ks_block_cnt_o(a_cnt), .dbg_state_o(a_dbg)
    );

    stream_xor_engine #(.DATA_WIDTH(80), .WORD_WIDTH(8)) u_dec (
        .clk(clk), .rst(rst), .ks_block_i(ks_block), .ks_end_block_i(ks_end),
        .ks_next_data_o(b_next), .data_valid_i(b_valid), .data_ready_o(b_ready),
        .data_i(b_data), .out_valid_o(b_out_valid), .out_ready_i(b_out_ready),
        .data_o(b_data_o), .ks_block_cnt_o(b_cnt), .dbg_state_o(b_dbg)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [79:0] blk(input int n);
        logic [79:0] v;
        v = '0;
        if (n == 0) v = 80'h0123456789ABCDEF0011;
        else for (int k = 0; k < 10; k++) v[k*8 +: 8] = 8'((n * 37 + k * 11 + 5) & 255);
        return v;
    endfunction

    // Generator model knobs (written by the main sequence only).
    int gen_gap   = 2;
    int gen_limit = 100;
    logic gen_sel = 1'b0;

    // Monitor / scoreboard state.
    logic [7:0] exp_q[$];
    logic [7:0] out_log [64];
    int         log_cyc [64];
    logic [7:0] rec [64];
    int log_n = 0, rec_n = 0, in_cnt = 0, stall_n = 0, pulses = 0, wc = 0, cyc = 0;
    logic prev_next = 1'b0;

    logic [7:0] hand [10] = '{8'h11, 8'h00, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
    logic [7:0] pt [40];

    // Keystream generator: presents a block, drops end_block after each request
    // for gen_gap cycles, and never presents block number gen_limit or later.
    initial begin
        int   blk_n;
        int   gap;
        logic pend;
        blk_n = 0; gap = 3; pend = 1'b0;
        ks_block = blk(0); ks_end = 1'b0;
        forever begin
            @(negedge clk);
            pend = gen_sel ? b_next : a_next;
            if (pend) begin
                pulses++;
                check("nd_with_end", ks_end, 1);
                check("nd_consec", prev_next, 0);
            end
            prev_next = pend;
            @(posedge clk); #1;
            if (!rst) begin
                blk_n = 0; gap = 3; ks_block = blk(0); ks_end = 1'b0;
            end else if (pend) begin
                blk_n++;
                ks_block = blk(blk_n);
                if (gen_gap == 0 && blk_n < gen_limit) ks_end = 1'b1;
                else begin ks_end = 1'b0; gap = gen_gap; end
            end else if (!ks_end) begin
                if (gap > 0) gap--;
                else if (blk_n < gen_limit) ks_end = 1'b1;
            end
        end
    end

    // Monitor: expected words pushed on accepted inputs, popped on accepted outputs.
    initial begin
        logic [79:0] bv;
        logic [7:0]  e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                exp_q.delete();
                wc = 0;
            end else begin
                if (a_out_valid && a_out_ready) begin
                    if (exp_q.size() == 0) check("sb_unexpected", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        check("sb_data", a_data_o, e);
                    end
                    if (log_n < 64) begin out_log[log_n] = a_data_o; log_cyc[log_n] = cyc; end
                    log_n++;
                end
                if (a_valid && a_ready) begin
                    bv = blk(wc / 10);
                    exp_q.push_back(a_data ^ bv[(wc % 10) * 8 +: 8]);
                    wc++;
                    in_cnt++;
                end
                if (a_valid && !a_ready) stall_n++;
                if (b_out_valid && b_out_ready) begin
                    if (rec_n < 64) rec[rec_n] = b_data_o;
                    rec_n++;
                end
            end
        end
    end

    task automatic send_a(input logic [7:0] d);
        int t;
        t = 0;
        a_valid = 1'b1; a_data = d;
        @(negedge clk);
        while (!a_ready && t < 100) begin t++; @(negedge clk); end
        if (!a_ready) check("send_a_timeout", 0, 1);
        @(posedge clk); #1;
        a_valid = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] d);
        int t;
        t = 0;
        b_valid = 1'b1; b_data = d;
        @(negedge clk);
        while (!b_ready && t < 100) begin t++; @(negedge clk); end
        if (!b_ready) check("send_b_timeout", 0, 1);
        @(posedge clk); #1;
        b_valid = 1'b0;
    endtask

    task automatic wait_a_ready();
        int t;
        t = 0;
        @(negedge clk);
        while (!a_ready && t < 100) begin t++; @(negedge clk); end
        if (!a_ready) check("wait_ready_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic clear_counts();
        pulses = 0; log_n = 0; rec_n = 0; in_cnt = 0; stall_n = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        clear_counts();
        #2 rst = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        int t;
        a_valid = 0; a_data = 0; a_out_ready = 1;
        b_valid = 0; b_data = 0; b_out_ready = 1;

        // Reset state.
        repeat (2) @(posedge clk); #1;
        check("rst_out_valid", a_out_valid, 0);
        check("rst_data_o", a_data_o, 0);
        check("rst_ready", a_ready, 0);
        check("rst_next", a_next, 0);
        check("rst_cnt", a_cnt, 0);
        check("rst_state", a_dbg, 0);

        // Basic block: ten zero words expose the keystream bytes in order.
        gen_gap = 2; gen_limit = 1;
        do_reset();
        for (int i = 0; i < 10; i++) send_a(8'h00);
        repeat (3) @(posedge clk); #1;
        check("basic_words", log_n, 10);
        for (int i = 0; i < 10; i++) check("basic_data", out_log[i], hand[i]);
        check("basic_back_to_back", log_cyc[9] - log_cyc[0], 9);
        check("basic_pulses", pulses, 1);
        check("basic_cnt", a_cnt, 1);

        // Fast path: next block already waiting at word 9.
        gen_gap = 0; gen_limit = 2;
        do_reset();
        wait_a_ready();
        stall_n = 0;
        for (int i = 0; i < 20; i++) send_a(8'(i * 13 + 1));
        repeat (3) @(posedge clk); #1;
        check("fast_no_stall", stall_n, 0);
        check("fast_words", log_n, 20);
        check("fast_back_to_back", log_cyc[19] - log_cyc[0], 19);
        check("fast_pulses", pulses, 2);
        check("fast_cnt", a_cnt, 2);

        // Starved block: generator holds end_block low for 30 cycles after word 9.
        gen_gap = 2; gen_limit = 1;
        do_reset();
        for (int i = 0; i < 10; i++) send_a(8'(i + 8'h40));
        a_valid = 1'b1; a_data = 8'h5A;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check("starve_ready", a_ready, 0);
            check("starve_next", a_next, 0);
        end
        gen_limit = 2;
        t = 0;
        @(negedge clk);
        while (!ks_end && t < 20) begin t++; @(negedge clk); end
        check("starve_end_rise", ks_end, 1);
        check("starve_capture_ready", a_ready, 0);
        check("starve_capture_next", a_next, 1);
        @(negedge clk);
        check("starve_resume_ready", a_ready, 1);
        @(posedge clk); #1;
        a_valid = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("starve_words", log_n, 11);
        check("starve_cnt", a_cnt, 2);

        // Backpressure: downstream stalls 5 cycles while word 4 is held.
        gen_gap = 2; gen_limit = 1;
        do_reset();
        fork
            begin
                for (int i = 0; i < 10; i++) send_a(8'h00);
            end
            begin
                int w;
                w = 0;
                @(negedge clk); #1;
                while (in_cnt < 5 && w < 100) begin w++; @(negedge clk); #1; end
                @(posedge clk); #1;
                a_out_ready = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check("bp_ready", a_ready, 0);
                    check("bp_valid", a_out_valid, 1);
                    check("bp_hold", a_data_o, hand[4]);
                end
                @(posedge clk); #1;
                a_out_ready = 1'b1;
            end
        join
        repeat (3) @(posedge clk); #1;
        check("bp_words", log_n, 10);
        for (int i = 0; i < 10; i++) check("bp_data", out_log[i], hand[i]);

        // Async reset at word 4.
        gen_gap = 2; gen_limit = 100;
        do_reset();
        for (int i = 0; i < 4; i++) send_a(8'h00);
        #2 rst = 1'b0;
        #1;
        check("arst_out_valid", a_out_valid, 0);
        check("arst_data_o", a_data_o, 0);
        check("arst_ready", a_ready, 0);
        check("arst_next", a_next, 0);
        check("arst_cnt", a_cnt, 0);
        @(negedge clk);
        @(negedge clk);
        clear_counts();
        #2 rst = 1'b1;
        send_a(8'h00);
        repeat (3) @(posedge clk); #1;
        check("arst_words", log_n, 1);
        check("arst_first", out_log[0], 8'h11);
        check("arst_cnt_after", a_cnt, 1);

        // Round trip: encrypt 40 random words, then decrypt on the second instance.
        gen_gap = 2; gen_limit = 100; gen_sel = 1'b0;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            pt[i] = 8'($urandom_range(0, 255));
            send_a(pt[i]);
        end
        repeat (3) @(posedge clk); #1;
        check("rt_enc_words", log_n, 40);
        gen_sel = 1'b1;
        do_reset();
        for (int i = 0; i < 40; i++) send_b(out_log[i]);
        repeat (3) @(posedge clk); #1;
        check("rt_dec_words", rec_n, 40);
        for (int i = 0; i < 40; i++) check("rt_data", rec[i], pt[i]);
        gen_sel = 1'b0;

        check("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
